// File: rtl/err_meas_ctrl_pkg.sv
// err_meas_ctrl_pkg: shared state encoding and parameter defaults for the MER measurement sequencer
package err_meas_ctrl_pkg;
    localparam int LFSR_LEN    = 4;
    localparam int SETTLE_DEF  = 16;
    localparam int CAP_DLY_DEF = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_ACCUM   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;
endpackage

// File: rtl/err_meas_ctrl_win_cnt.sv
// meas_win_cnt: enabled window counter with sync clear and terminal-count compare against a runtime limit
module meas_win_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == i_limit - W'(1));

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/err_meas_ctrl.sv
// err_meas_ctrl: frames squared-error accumulator windows and hands the captured mean to readout
module err_meas_ctrl
    import err_meas_ctrl_pkg::*;
#(
    parameter int LOG2_N  = LFSR_LEN,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int CAP_DLY = CAP_DLY_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               start,
    input  logic               continuous,
    input  logic               abort,
    input  logic signed [17:0] acc_in,
    input  logic signed [17:0] thresh,
    output logic               hold,
    output logic               busy,
    output logic signed [17:0] result,
    output logic               result_valid,
    input  logic               result_ack,
    output logic               mer_ok,
    output logic               overrun
);
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] L_SETTLE = CW'(SETTLE);
    localparam logic [CW-1:0] L_WIN    = CW'(2 ** LOG2_N);
    localparam logic [CW-1:0] L_CAP    = CW'(CAP_DLY + 1);

    state_t             r_state;
    logic signed [17:0] r_result;
    logic               r_valid;
    logic               r_mer_ok;
    logic               r_overrun;
    logic [CW-1:0]      w_limit;
    logic               w_en;
    logic               w_clr;
    logic               w_tc;

    assign hold         = (r_state != S_ACCUM);
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;
    assign result_valid = r_valid;
    assign mer_ok       = r_mer_ok;
    assign overrun      = r_overrun;

    // counter restarts on every state change so each phase counts from zero
    assign w_en  = clk_en && busy;
    assign w_clr = abort || w_tc || (!busy && start);

    always_comb begin
        w_limit = (r_state == S_SETTLE) ? L_SETTLE :
                  (r_state == S_ACCUM)  ? L_WIN : L_CAP;
    end

    meas_win_cnt #(.W(CW)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_mer_ok  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (result_ack)
                r_valid <= 1'b0;
            if (abort)
                r_state <= S_IDLE;
            else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state   <= S_SETTLE;
                            r_overrun <= 1'b0;
                        end
                    end
                    S_SETTLE: if (w_tc) r_state <= S_ACCUM;
                    S_ACCUM:  if (w_tc) r_state <= S_CAPTURE;
                    S_CAPTURE: begin
                        // a capture overrides a same-cycle ack; only an unacked result counts as overrun
                        if (w_tc) begin
                            r_state  <= continuous ? S_ACCUM : S_IDLE;
                            r_result <= acc_in;
                            r_mer_ok <= (acc_in <= thresh);
                            r_valid  <= 1'b1;
                            if (r_valid && !result_ack)
                                r_overrun <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_err_meas_ctrl.sv
// tb_err_meas_ctrl: random-stimulus bench with a behavioural accumulator and window-mean reference
module tb_err_meas_ctrl;
    localparam int LOG2_N  = 4;
    localparam int SETTLE  = 2;
    localparam int CAP_DLY = 1;
    localparam int N       = 1 << LOG2_N;
    localparam int PER     = N + CAP_DLY + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clk_en = 1'b0;
    logic               start = 1'b0;
    logic               continuous = 1'b0;
    logic               abort = 1'b0;
    logic               result_ack = 1'b0;
    logic signed [17:0] thresh = 18'sd10000;
    logic signed [17:0] acc_in;
    logic signed [17:0] result;
    logic               hold, busy, result_valid, mer_ok, overrun;

    int     err = 0;
    int     err_fix = 32768;
    bit     rand_err = 1'b0;
    int     samp[$];
    longint acc_sum = 0;
    int     acc_q = 0;
    int     hold_cnt = 0;
    int     n_chk = 0;
    int     n_fail = 0;

    err_meas_ctrl #(.LOG2_N(LOG2_N), .SETTLE(SETTLE), .CAP_DLY(CAP_DLY)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .acc_in       (acc_in),
        .thresh       (thresh),
        .hold         (hold),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .mer_ok       (mer_ok),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic longint sq(input int e);
        return (longint'(e) * longint'(e)) >>> 17;
    endfunction

    // squared-error accumulator: sums while hold is low, output register one enabled cycle late
    assign acc_in = 18'(acc_q);
    always @(posedge clk) begin
        if (reset) begin
            acc_sum <= 0;
            acc_q   <= 0;
        end else if (clk_en) begin
            acc_sum <= hold ? 64'sd0 : acc_sum + sq(err);
            acc_q   <= int'(acc_sum >>> LOG2_N);
        end
        if (clk_en && !hold && !reset)
            hold_cnt <= hold_cnt + 1;
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic en);
        clk_en = en;
        if (en)
            err = rand_err ? int'($urandom_range(262142)) - 131071 : err_fix;
        @(posedge clk);
        if (en)
            samp.push_back(err);
        #1;
    endtask

    task automatic ens(input int n);
        repeat (n) begin
            step(1'b0);
            step(1'b1);
        end
    endtask

    task automatic go();
        start = 1'b1;
        samp.delete();
        step(1'b0);
        start = 1'b0;
    endtask

    task automatic ack();
        result_ack = 1'b1;
        step(1'b0);
        result_ack = 1'b0;
    endtask

    // mean of the squared errors presented during window k after a start
    function automatic int exp_win(input int k);
        longint s = 0;
        for (int i = 0; i < N; i++)
            if (SETTLE + k * PER + i < samp.size())
                s += sq(samp[SETTLE + k * PER + i]);
        return int'(s / N);
    endfunction

    task automatic chk_cap(input string tag, input int k);
        int e;
        e = exp_win(k);
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_result"}, result, e);
        chk({tag, "_mer_ok"}, mer_ok, (e <= int'(thresh)));
    endtask

    initial begin
        int h0;
        int w2;
        repeat (2) step(1'b0);
        chk("rst_hold", hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_mer_ok", mer_ok, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        step(1'b0);

        go();
        chk("single_busy", busy, 1);
        chk("single_hold_settle", hold, 1);
        ens(SETTLE);
        chk("single_hold_fall", hold, 0);
        h0 = hold_cnt;
        ens(N);
        chk("single_hold_rise", hold, 1);
        ens(CAP_DLY);
        chk("single_not_yet", result_valid, 0);
        ens(1);
        chk_cap("single", 0);
        chk("single_const", result, 8192);
        chk("single_idle", busy, 0);
        chk("single_hold_len", hold_cnt - h0, N);
        ack();
        chk("ack_clears", result_valid, 0);

        thresh = 18'sd8191;
        go();
        ens(SETTLE + PER);
        chk_cap("thr_lo", 0);
        chk("thr_lo_fail", mer_ok, 0);
        ack();
        thresh = 18'sd8192;
        go();
        ens(SETTLE + PER);
        chk_cap("thr_eq", 0);
        chk("thr_eq_pass", mer_ok, 1);
        ack();

        continuous = 1'b1;
        go();
        h0 = hold_cnt;
        ens(SETTLE);
        for (int k = 0; k < 4; k++) begin
            ens(PER - 1);
            chk("cont_gap", result_valid, 0);
            ens(1);
            chk_cap("cont", k);
            chk("cont_const", result, 8192);
            ack();
        end
        chk("cont_hold_len", hold_cnt - h0, 4 * N);
        chk("cont_overrun", overrun, 0);
        chk("cont_busy", busy, 1);
        continuous = 1'b0;
        ens(PER);
        chk_cap("cont_last", 4);
        chk("cont_stop", busy, 0);
        ack();

        rand_err = 1'b1;
        continuous = 1'b1;
        go();
        ens(SETTLE);
        for (int k = 0; k < 6; k++) begin
            thresh = 18'($urandom_range(80000));
            ens(PER);
            chk_cap("rand", k);
            ack();
        end
        continuous = 1'b0;
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
        chk("rand_abort", busy, 0);

        continuous = 1'b1;
        go();
        ens(SETTLE + PER);
        chk_cap("ov_first", 0);
        chk("ov_first_flag", overrun, 0);
        ens(PER - 1);
        step(1'b0);
        result_ack = 1'b1;
        step(1'b1);
        result_ack = 1'b0;
        chk_cap("coinc", 1);
        chk("coinc_no_overrun", overrun, 0);
        ens(PER);
        chk_cap("ov", 2);
        chk("ov_flag", overrun, 1);
        w2 = exp_win(2);
        continuous = 1'b0;
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
        chk("ov_abort_busy", busy, 0);
        chk("ov_abort_valid", result_valid, 1);
        chk("ov_abort_sticky", overrun, 1);

        rand_err = 1'b0;
        go();
        chk("start_clr_overrun", overrun, 0);
        chk("start_keeps_valid", result_valid, 1);
        ens(SETTLE + 7);
        chk("abort_pre_hold", hold, 0);
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
        chk("abort_hold", hold, 1);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, w2);
        chk("abort_valid", result_valid, 1);
        ack();
        go();
        ens(SETTLE + PER);
        chk_cap("restart", 0);
        chk("restart_const", result, 8192);

        rand_err = 1'b1;
        go();
        for (int i = 0; i < SETTLE + PER - 1; i++) begin
            start = (i % 3 == 0);
            step(1'b0);
            start = (i % 5 == 2);
            step(1'b1);
            start = 1'b0;
        end
        chk("sb_not_yet", result_valid, 1);
        chk("sb_busy", busy, 1);
        ens(1);
        chk_cap("sb", 0);
        chk("sb_idle", busy, 0);

        thresh = 18'sd100000;
        go();
        ens(SETTLE + N + 1);
        chk("rc_in_capture", hold, 1);
        chk("rc_busy", busy, 1);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        chk("rc_hold", hold, 1);
        chk("rc_busy_rst", busy, 0);
        chk("rc_result", result, 0);
        chk("rc_valid", result_valid, 0);
        chk("rc_mer_ok", mer_ok, 0);
        chk("rc_overrun", overrun, 0);
        go();
        ens(SETTLE + PER);
        chk_cap("post_reset", 0);
        chk("post_reset_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/err_meas_ctrl.md
# err_meas_ctrl

Sequencer for the squared-error accumulator in the MER measurement path. It drives the accumulator's `hold` (clear) input to frame fixed-length measurement windows of 2^LOG2_N symbols. It captures the window mean from the accumulator output and hands it to the status/readout logic through a valid/ack handshake, with a threshold flag and an overrun flag. It supports single-shot and continuous measurement, plus a settle period that lets loops converge after start.

## Interface
- LOG2_N, default `LFSR_LEN: log2 of symbols per window. Must equal the accumulator's shift.
- SETTLE, default 16: enabled cycles with accumulator held clear after `start`. Legal range is ≥1.
- CAP_DLY, default 1: accumulator output register latency in enabled cycles.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  symbol strobe, the same one the accumulator uses
- start  in  1  begin measurement; single-cycle pulse, sampled every clk
- continuous  in  1  re-arm after each capture; sampled at capture
- abort  in  1  return to IDLE; sampled every clk; has priority over `start`
- acc_in  in  18 signed  accumulator output, 1s17 mean squared error
- thresh  in  18 signed  pass threshold, 1s17
- hold  out  1  accumulator clear/hold, Moore-decoded from state
- busy  out  1  high in every state except IDLE
- result  out  18 signed  captured window mean, 1s17
- result_valid  out  1  result available
- result_ack  in  1  consumer ack, level, sampled every clk
- mer_ok  out  1  result ≤ thresh (signed), registered with result
- overrun  out  1  sticky: a capture occurred while result_valid was still high

## Operation
- FSM states: IDLE, SETTLE, ACCUM, CAPTURE. One shared counter, LOG2_N+1 bits, advanced only on clk_en.
- `hold` is 0 only in ACCUM; it is 1 in all other states, including during reset.
- IDLE → SETTLE on `start` (any clk, regardless of clk_en). Counter is cleared and `overrun` is cleared.
- SETTLE → ACCUM on the SETTLE-th enabled edge in SETTLE. Counter is cleared.
- ACCUM → CAPTURE on the 2^LOG2_N-th enabled edge in ACCUM. Exactly 2^LOG2_N samples are summed.
- CAPTURE:
  - On the (CAP_DLY+1)-th enabled edge, register `result` ← acc_in and `mer_ok` ← (acc_in ≤ thresh), and set `result_valid`.
  - Then go to ACCUM if `continuous`=1, else IDLE.
  - The accumulator was cleared by `hold` during CAPTURE, so no settle is needed.
- `start` while busy: ignored.
- `abort` in any state: → IDLE on that clk; counter cleared. `result`, `result_valid`, `mer_ok` and `overrun` are untouched.
- Handshake:
  - `result_valid` clears on the clk after `result_ack` is sampled high.
  - If a capture and an ack land on the same clk, the capture wins: valid stays 1 and `overrun` is not set.
  - If a capture occurs with valid=1 and no ack, `result` is overwritten and `overrun` is set to 1.
- Continuous mode: window period is 2^LOG2_N + CAP_DLY + 1 enabled cycles. Samples during CAPTURE are discarded.
- The threshold compare is signed and full width. No saturation is needed: acc_in ≥ 0 by construction.

## Timing
- Reset values: hold=1, busy=0, result=0, result_valid=0, mer_ok=0, overrun=0, state=IDLE, counter=0.
- Reset mid-window: same values at the next edge; any partial window is discarded.
- `busy` rises the clk after `start`.
- `hold` falls the clk after the SETTLE-th enabled edge. It rises the clk after the 2^LOG2_N-th ACCUM enabled edge.
- Capture latency: `result_valid` rises the clk after the (CAP_DLY+1)-th enabled edge in CAPTURE.
- Single-shot, start to valid: SETTLE + 2^LOG2_N + CAP_DLY + 1 enabled edges, plus one clk.
- With clk_en held low, the FSM and counter freeze. Only the start, abort and ack paths remain live.

## Structure
- Shared package/defines: the state encoding (2 bits: IDLE=0, SETTLE=1, ACCUM=2, CAPTURE=3) and the SETTLE/CAP_DLY defaults, alongside `LFSR_LEN in defines.vh.
- One natural sub-module: `meas_win_cnt`, an enabled counter with sync clear and terminal-count compare against a runtime limit (SETTLE, 2^LOG2_N, CAP_DLY+1).
- All other logic (FSM, result/handshake registers) lives in the top module.

## Test plan
Setup for all scenarios: LOG2_N=4, SETTLE=2, CAP_DLY=1, a real accumulator instance in the loop, clk_en every 2nd clk.

- Single-shot: err=0.25 (32768) constant, thresh=10000, start pulse → exactly 16 ACCUM enables; result=8192, mer_ok=1, valid after 2+16+2 enables; return to IDLE.
- Threshold: same stimulus with thresh=8191 → result=8192, mer_ok=0. With thresh=8192 → mer_ok=1.
- Continuous: continuous=1, ack each result promptly → valid pulses every 18 enables, all results 8192, hold low for exactly 16 enables per window, overrun=0.
- Overrun and simultaneous events:
  - Continuous run with no ack → second capture sets overrun=1 and updates result.
  - Ack coincident with a capture → valid stays 1 and overrun unchanged.
  - A later start clears overrun.
- Abort and restart: abort mid-ACCUM (after 7 enables) → IDLE and hold=1 next clk, previous result/valid kept. A subsequent start gives a full correct window (result=8192).
- Reset and start-while-busy:
  - Sync reset asserted mid-CAPTURE → all outputs at reset values next clk.
  - Start pulses during SETTLE/ACCUM are ignored; window length is unchanged.
